// File: rtl/baccarat_ctrl.sv
// Baccarat hand sequencer: pulses card load strobes, applies the
// third-card rules and reports the winner once the hand is complete.
module baccarat_ctrl #(
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step,
   input  logic [SW-1:0] pscore,
   input  logic [SW-1:0] dscore,
   input  logic [SW-1:0] pcard3,
   output logic          load_pcard1,
   output logic          load_pcard2,
   output logic          load_pcard3,
   output logic          load_dcard1,
   output logic          load_dcard2,
   output logic          load_dcard3,
   output logic          player_win,
   output logic          dealer_win,
   output logic          done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_P1,
      S_D1,
      S_P2,
      S_D2,
      S_EVAL1,
      S_P3,
      S_EVAL2,
      S_D3,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] w_v;
   logic          w_natural;
   logic          w_draw;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Face cards and tens carry no points in the banker table.
   assign w_v       = (pcard3 <= SW'(9)) ? pcard3 : '0;
   assign w_natural = (pscore >= SW'(8)) || (dscore >= SW'(8));

   always_comb begin
      w_draw = 1'b0;
      if (dscore <= SW'(2))
         w_draw = 1'b1;
      else if (dscore == SW'(3))
         w_draw = (w_v != SW'(8));
      else if (dscore == SW'(4))
         w_draw = (w_v >= SW'(2)) && (w_v <= SW'(7));
      else if (dscore == SW'(5))
         w_draw = (w_v >= SW'(4)) && (w_v <= SW'(7));
      else if (dscore == SW'(6))
         w_draw = (w_v == SW'(6)) || (w_v == SW'(7));
   end

   always_comb begin
      w_next      = r_state;
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      done        = 1'b0;
      player_win  = 1'b0;
      dealer_win  = 1'b0;
      case (r_state)
         S_IDLE: if (step) w_next = S_P1;
         S_P1: begin
            load_pcard1 = 1'b1;
            if (step) w_next = S_D1;
         end
         S_D1: begin
            load_dcard1 = 1'b1;
            if (step) w_next = S_P2;
         end
         S_P2: begin
            load_pcard2 = 1'b1;
            if (step) w_next = S_D2;
         end
         S_D2: begin
            load_dcard2 = 1'b1;
            if (step) w_next = S_EVAL1;
         end
         S_EVAL1: begin
            if (step) begin
               if (w_natural)              w_next = S_DONE;
               else if (pscore <= SW'(5))  w_next = S_P3;
               else if (dscore <= SW'(5))  w_next = S_D3;
               else                        w_next = S_DONE;
            end
         end
         S_P3: begin
            load_pcard3 = 1'b1;
            if (step) w_next = S_EVAL2;
         end
         S_EVAL2: begin
            if (step) w_next = w_draw ? S_D3 : S_DONE;
         end
         S_D3: begin
            load_dcard3 = 1'b1;
            if (step) w_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            player_win = (pscore >= dscore);
            dealer_win = (dscore >= pscore);
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Directed vector bench for baccarat_ctrl: table of per-edge stimulus
// with hand-computed outputs, plus a free-running full-hand sequence.
module tb_baccarat_ctrl;

   logic       clk = 1'b0;
   logic       reset, step;
   logic [3:0] pscore, dscore, pcard3;
   logic       lp1, lp2, lp3, ld1, ld2, ld3, pw, dw, dn;
   logic [8:0] obs;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   baccarat_ctrl #(.SW(4)) dut (
      .clk(clk), .reset(reset), .step(step),
      .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
      .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
      .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
      .player_win(pw), .dealer_win(dw), .done(dn)
   );

   assign obs = {lp1, ld1, lp2, ld2, lp3, ld3, pw, dw, dn};

   localparam logic [8:0] O_NONE = 9'h000;
   localparam logic [8:0] O_P1   = 9'h100;
   localparam logic [8:0] O_D1   = 9'h080;
   localparam logic [8:0] O_P2   = 9'h040;
   localparam logic [8:0] O_D2   = 9'h020;
   localparam logic [8:0] O_P3   = 9'h010;
   localparam logic [8:0] O_D3   = 9'h008;
   localparam logic [8:0] O_PW   = 9'h005;
   localparam logic [8:0] O_DW   = 9'h003;
   localparam logic [8:0] O_TIE  = 9'h007;

   typedef struct {
      logic       rst;
      logic       stp;
      logic [3:0] ps;
      logic [3:0] ds;
      logic [3:0] pc;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic [3:0] p,
                      input logic [3:0] d, input logic [3:0] c,
                      input logic [8:0] e);
      vec_t v;
      v.rst = r; v.stp = s; v.ps = p; v.ds = d; v.pc = c; v.exp = e;
      vecs.push_back(v);
   endtask

   // Reset, then step through the fixed four-card deal into EVAL1.
   task automatic deal(input logic [3:0] p, input logic [3:0] d);
      add(0, 1, p, d, 0, O_NONE);
      add(1, 1, p, d, 0, O_P1);
      add(1, 1, p, d, 0, O_D1);
      add(1, 1, p, d, 0, O_P2);
      add(1, 1, p, d, 0, O_D2);
      add(1, 1, p, d, 0, O_NONE);
   endtask

   task automatic check(input string nm, input logic [8:0] act,
                        input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   initial begin
      int edges;
      int order[$];
      int exp_order[6];
      logic seen_done;

      reset = 1'b0; step = 1'b0;
      pscore = 0; dscore = 0; pcard3 = 0;

      deal(9, 3);
      add(1, 1, 9, 3, 0, O_PW);
      add(1, 0, 9, 3, 0, O_PW);
      add(1, 1, 2, 8, 0, O_DW);

      deal(4, 6);
      add(1, 1, 4, 6, 0, O_P3);
      add(1, 1, 4, 6, 7, O_NONE);
      add(1, 1, 4, 6, 7, O_D3);
      add(1, 1, 1, 5, 7, O_DW);

      deal(7, 5);
      add(1, 1, 7, 5, 0, O_D3);
      add(1, 1, 7, 7, 0, O_TIE);

      deal(3, 3);
      add(1, 1, 3, 3, 0, O_P3);
      add(1, 1, 3, 3, 8, O_NONE);
      add(1, 1, 3, 3, 8, O_TIE);

      deal(3, 4);
      add(1, 1, 3, 4, 0, O_P3);
      add(1, 1, 3, 4, 12, O_NONE);
      add(1, 1, 3, 4, 12, O_DW);

      deal(6, 6);
      add(1, 1, 6, 6, 0, O_TIE);

      deal(5, 9);
      add(1, 1, 5, 9, 0, O_DW);

      deal(5, 5);
      add(1, 1, 5, 5, 0, O_P3);
      add(1, 1, 5, 5, 3, O_NONE);
      add(1, 1, 5, 5, 3, O_TIE);

      deal(5, 5);
      add(1, 1, 5, 5, 0, O_P3);
      add(1, 1, 5, 5, 4, O_NONE);
      add(1, 1, 5, 5, 4, O_D3);
      add(1, 1, 6, 5, 4, O_PW);

      deal(6, 7);
      add(1, 1, 6, 7, 0, O_DW);

      add(0, 1, 0, 0, 0, O_NONE);
      add(1, 0, 0, 0, 0, O_NONE);
      add(1, 1, 0, 0, 0, O_P1);
      add(1, 1, 0, 0, 0, O_D1);
      for (int i = 0; i < 5; i++) add(1, 0, 9, 9, 0, O_D1);
      add(1, 1, 4, 6, 0, O_P2);
      add(1, 1, 4, 6, 0, O_D2);
      add(1, 1, 4, 6, 0, O_NONE);
      add(1, 1, 4, 6, 0, O_P3);
      add(0, 1, 4, 6, 0, O_NONE);
      add(0, 0, 4, 6, 0, O_NONE);
      add(1, 1, 4, 6, 0, O_P1);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset  = vecs[i].rst;
         step   = vecs[i].stp;
         pscore = vecs[i].ps;
         dscore = vecs[i].ds;
         pcard3 = vecs[i].pc;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), obs, vecs[i].exp);
      end

      // Free-running full six-card hand with step held high.
      exp_order = '{8, 7, 6, 5, 4, 3};
      @(negedge clk);
      reset = 1'b0; step = 1'b1;
      pscore = 2; dscore = 2; pcard3 = 5;
      @(posedge clk);
      #1;
      check("hold_reset", obs, O_NONE);
      @(negedge clk);
      reset = 1'b1;
      edges = 0;
      seen_done = 1'b0;
      while (!seen_done && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
         check($sformatf("onehot_e%0d", edges),
               9'($countones(obs[8:3]) <= 1), 9'd1);
         for (int b = 8; b >= 3; b--)
            if (obs[b]) order.push_back(b);
         seen_done = dn;
      end
      check("hand_edges", 9'(edges), 9'd9);
      check("strobe_count", 9'(order.size()), 9'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < order.size())
            check($sformatf("order%0d", k), 9'(order[k]),
                  9'(exp_order[k]));
      end
      check("hand_result", obs, O_TIE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
